// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: two-master arbiter and wait-state sequencer in front of
// the data Memory block. Master 0 is the pipeline MEM stage (stalled through
// freeze), master 1 is the debug/loader port. Each access is held on the
// memory bus for WAIT_CYCLES+1 cycles and completes with a one-cycle ready.
// Optional build macro: MEM_ALIGN_CHECK_EN rejects word-misaligned requests
// with a one-cycle err pulse instead of touching Memory.
module mem_access_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 3,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              freeze,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_gnt_q;
  logic              gnt_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;

  logic              grant_vld;
  logic              grant_sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              misalign;
  logic              cnt_zero;

`ifdef MEM_ALIGN_CHECK_EN
  logic              err_q;
`endif

  assign cnt_zero = (cnt_q == '0);

  // Arbitration: a lone request wins; on contention m0 wins unless m0 was
  // served last, so neither master can be starved.
  always_comb begin
    grant_vld = m0_req | m1_req;
    grant_sel = 1'b0;
    if (m0_req && m1_req) begin
      grant_sel = ~last_gnt_q;
    end else begin
      grant_sel = m1_req;
    end
    sel_we    = grant_sel ? m1_we    : m0_we;
    sel_addr  = grant_sel ? m1_addr  : m0_addr;
    sel_wdata = grant_sel ? m1_wdata : m0_wdata;
`ifdef MEM_ALIGN_CHECK_EN
    misalign  = (sel_addr[1:0] != 2'b00);
`else
    misalign  = 1'b0;
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // FSM next state and memory/handshake strobes; memory strobes are forced
  // low while rst is high so a reset can never leave a partial write behind.
  always_comb begin
    state_nxt = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_nxt = misalign ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        mem_read  = ~we_q;
        mem_write = we_q & cnt_zero;
        if (cnt_zero) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        m0_ready  = ~gnt_q;
        m1_ready  = gnt_q;
        m0_rdata  = gnt_q ? '0 : rdata_q;
        m1_rdata  = gnt_q ? rdata_q : '0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign freeze = m0_req & ~m0_ready;

`ifdef MEM_ALIGN_CHECK_EN
  assign err = (state_q == DONE) & err_q;
`else
  assign err = 1'b0;
`endif

  // Grant latch, wait counter and fairness history
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            gnt_q     <= grant_sel;
            we_q      <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            cnt_q     <= CNT_W'(WAIT_CYCLES);
`ifdef MEM_ALIGN_CHECK_EN
            err_q     <= misalign;
`endif
            if (misalign) begin
              last_gnt_q <= grant_sel;
            end
          end
        end
        ACCESS: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            last_gnt_q <= gnt_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Read data capture on the final access cycle; writes and rejected
  // requests return zero. Only observed in DONE, so no reset is needed.
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          rdata_q <= '0;
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          rdata_q <= we_q ? '0 : mem_rdata;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a WAIT_CYCLES=3 instance backed by a small
// memory model, plus a WAIT_CYCLES=0 instance with fixed read data.
// Stimulus pushes expected completions into a queue; a monitor pops them
// whenever a ready pulse appears.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m1_ready, freeze, mem_read, mem_write, err;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        b_m1_req, b_m1_we;
  logic [31:0] b_m1_addr, b_m1_wdata;
  logic        m0_ready_b, m1_ready_b, freeze_b, mem_read_b, mem_write_b, err_b;
  logic [31:0] m0_rdata_b, m1_rdata_b, mem_addr_b, mem_wdata_b;

  logic [31:0] mem [0:1023];

  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ready_seen = 0;
  int   wr_cnt = 0, rd_cnt = 0, frz_cnt = 0, rd0_cnt = 0, wr0_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .freeze(freeze), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .err(err)
  );

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst),
    .m0_req(1'b0), .m0_we(1'b0), .m0_addr(32'h0), .m0_wdata(32'h0),
    .m0_ready(m0_ready_b), .m0_rdata(m0_rdata_b),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_ready(m1_ready_b), .m1_rdata(m1_rdata_b),
    .freeze(freeze_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_rdata(32'h0BAD_F00D), .err(err_b)
  );

  // Memory model: synchronous word write, combinational word read
  always @(posedge clk) if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[11:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: strobe counters plus scoreboard pop on every ready pulse
  always @(negedge clk) begin
    logic [3:0]  rdy;
    logic [31:0] rsel;
    logic        esel;
    if (mem_write)   wr_cnt++;
    if (mem_read)    rd_cnt++;
    if (freeze)      frz_cnt++;
    if (mem_read_b)  rd0_cnt++;
    if (mem_write_b) wr0_cnt++;
    rdy = {m1_ready_b, m0_ready_b, m1_ready, m0_ready};
    for (int i = 0; i < 4; i++) begin
      if (rdy[i]) begin
        case (i)
          0: rsel = m0_rdata;
          1: rsel = m1_rdata;
          2: rsel = m0_rdata_b;
          default: rsel = m1_rdata_b;
        endcase
        esel = (i < 2) ? err : err_b;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: port %0d at cycle %0d, none expected", i, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ready_port", i, e.port);
          chk("ready_cycle", cyc, e.cyc);
          chk("ready_rdata", rsel, e.data);
          chk("ready_err", {31'b0, esel}, {31'b0, e.err});
          ready_seen++;
        end
      end
    end
    if (!m0_ready) chk("m0_rdata_idle", m0_rdata, 32'h0);
    if (!m1_ready) chk("m1_rdata_idle", m1_rdata, 32'h0);
    if (!m0_ready && !m1_ready) chk("err_idle", {31'b0, err}, 32'h0);
  end

  task automatic wait_ready(input int tgt);
    int n = 0;
    while (ready_seen < tgt && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (ready_seen < tgt) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: seen %0d expected %0d", ready_seen, tgt);
    end
  endtask

  // Issue one access on a port (0/1 main DUT, 3 = m1 of the zero-wait DUT),
  // wait for its ready, then drop the request in the following cycle.
  task automatic do_access(input int port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_data,
                           input logic exp_err, input int lat);
    exp_t e;
    int   tgt;
    @(posedge clk);
    #1;
    case (port)
      0: begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
      1: begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
      default: begin b_m1_req = 1'b1; b_m1_we = we; b_m1_addr = addr; b_m1_wdata = wdata; end
    endcase
    e.port = port; e.data = exp_data; e.cyc = cyc + lat; e.err = exp_err;
    sb.push_back(e);
    tgt = ready_seen + 1;
    wait_ready(tgt);
    m0_req = 1'b0; m1_req = 1'b0; b_m1_req = 1'b0;
  endtask

  initial begin
    int   snap_wr, snap_rd, snap_frz, snap_rd0, k;
    exp_t e;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_ready", {31'b0, m0_ready}, 32'h0);
    chk("rst_m1_ready", {31'b0, m1_ready}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // m0 write: one write strobe, ready at t+5, freeze t..t+4
    snap_wr = wr_cnt; snap_frz = frz_cnt;
    do_access(0, 1'b1, 32'h400, 32'hDEAD_BEEF, 32'h0, 1'b0, 5);
    chk("t1_write_pulses", wr_cnt - snap_wr, 1);
    chk("t1_freeze_cycles", frz_cnt - snap_frz, 5);
    chk("t1_mem_content", mem[32'h100], 32'hDEAD_BEEF);

    // m0 read back: mem_read held for WAIT_CYCLES+1 cycles
    snap_rd = rd_cnt;
    do_access(0, 1'b0, 32'h400, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);
    chk("t2_read_cycles", rd_cnt - snap_rd, 4);

    // m1 write of a known value to 0x404; m1 traffic never freezes m0
    snap_frz = frz_cnt;
    do_access(1, 1'b1, 32'h404, 32'hCAFE_F00D, 32'h0, 1'b0, 5);
    chk("t4a_freeze_m1", frz_cnt - snap_frz, 0);

    // m1 write to 0x404 killed by reset on its final (write) cycle
    snap_wr = wr_cnt;
    @(posedge clk);
    #1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h404; m1_wdata = 32'h1234_5678;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t4_no_write", wr_cnt - snap_wr, 0);
    chk("t4_mem_kept", mem[32'h101], 32'hCAFE_F00D);

    // Both masters held: grants alternate m0,m1,m0,m1 (m0 first after reset)
    @(posedge clk);
    #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h400; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h404; m1_wdata = 32'h0;
    k = cyc;
    for (int j = 0; j < 4; j++) begin
      e.port = j % 2;
      e.data = (j % 2 == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D;
      e.cyc  = k + 5 + 6 * j;
      e.err  = 1'b0;
      sb.push_back(e);
    end
    wait_ready(ready_seen + 4);
    m0_req = 1'b0; m1_req = 1'b0;

    // Misaligned m0 read
    snap_rd = rd_cnt;
`ifdef MEM_ALIGN_CHECK_EN
    do_access(0, 1'b0, 32'h402, 32'h0, 32'h0, 1'b1, 1);
    chk("t6_no_read", rd_cnt - snap_rd, 0);
`else
    do_access(0, 1'b0, 32'h402, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);
    chk("t6_read_cycles", rd_cnt - snap_rd, 4);
`endif

    // Zero-wait instance: m1 read, ready at t+2, one read cycle
    snap_rd0 = rd0_cnt;
    do_access(3, 1'b0, 32'h10, 32'h0, 32'h0BAD_F00D, 1'b0, 2);
    chk("t5_read_cycles", rd0_cnt - snap_rd0, 1);
    chk("t5_no_write", wr0_cnt, 0);
    chk("t5_addr", mem_addr_b, 32'h10);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
